muldiv_unit: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit. It replaces the single-cycle combinational MUL/DIV paths of the EX-stage ALU.
- Radix-2 iterative datapath. Exact RISC-V semantics: high-half products, division by zero, signed overflow.
- Sits beside the ALU in EX. Valid/ready handshake on both sides lets the pipeline stall while the unit is busy.

---
 rtl/muldiv_pkg.sv | 51 +++++
 rtl/muldiv_sign_fix.sv | 29 ++
 rtl/muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M/RV64M multiply/divide unit and the EX-stage
// ALU decoder: operation encoding, FSM state encoding and default widths.
// The encoding matches ALU SELECT[2:0] for the M-extension select codes.
// Optional feature macro used by muldiv_unit: MULDIV_EARLY_OUT_EN.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int OP_W_DEFAULT = 3;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHU  = 3'd2,
    OP_MULHSU = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Bit 2 of the encoding separates the divide group from the multiply group.
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // Within the divide group, bit 1 selects the remainder instead of the quotient.
  function automatic logic op_is_rem(input muldiv_op_e op);
    return op[1];
  endfunction

  // rs1 is treated as signed for every signed multiply/divide; MUL uses the
  // signed path too since the low half of the product does not depend on it.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negation, LANES independent lanes
// of W bits each. Negating a value whose sign flag is set yields its absolute
// value, so the same block serves as operand abs() on the input side and as
// result sign correction on the output side.
// Ports:
//   value  [LANES*W-1:0]  packed input lanes, lane 0 in the low bits
//   negate [LANES-1:0]    per-lane negate enable
//   result [LANES*W-1:0]  packed output lanes
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int W     = 32,
  parameter int LANES = 1
) (
  input  logic [LANES*W-1:0] value,
  input  logic [LANES-1:0]   negate,
  output logic [LANES*W-1:0] result
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign result[gi*W +: W] = negate[gi] ? (~value[gi*W +: W] + W'(1))
                                            : value[gi*W +: W];
    end
  endgenerate

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Radix-2 iterative datapath: shift-add multiply, restoring divide, one step
// per cycle on operand magnitudes, with sign correction applied to the final
// step. Valid/ready handshakes on both sides; KILL aborts in-flight work.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   defined   - divide by zero, signed overflow and multiply by zero go
//               straight IDLE->DONE (result valid the cycle after acceptance)
//   undefined - every operation takes the full XLEN-step iteration
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   IN_VALID/IN_READY   request handshake (IN_READY = unit idle)
//   OP, DATA1, DATA2    operation code and rs1/rs2 operands
//   KILL                pipeline flush, aborts any in-flight operation
//   OUT_VALID/OUT_READY result handshake
//   RESULT              result, held stable while OUT_VALID is high
//   BUSY                unit not idle
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int OP_W = OP_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [OP_W-1:0] OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            KILL,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_e   state_reg, state_next;
  muldiv_op_e      op_in, op_reg;
  logic            accept;

  logic [XLEN-1:0] acc_hi_reg, acc_lo_reg, opb_reg, result_reg;
  logic            res_neg_reg;
  logic [CNT_W-1:0] cnt_reg;

  // ---------------------------------------------------------------------------
  // Input side: operand signs, magnitudes and result sign
  // ---------------------------------------------------------------------------
  logic            sign_a, sign_b, divisor_zero, res_neg_in;
  logic [2*XLEN-1:0] abs_pair;
  logic [XLEN-1:0] abs_a, abs_b;

  assign op_in        = muldiv_op_e'(OP[2:0]);
  assign sign_a       = op_a_signed(op_in) & DATA1[XLEN-1];
  assign sign_b       = op_b_signed(op_in) & DATA2[XLEN-1];
  assign divisor_zero = (DATA2 == '0);

  // Remainder follows the dividend sign. The quotient of a divide by zero must
  // stay all ones, so its sign correction is suppressed; the unsigned-style
  // iteration already produces all ones and the dividend as remainder.
  always_comb begin
    res_neg_in = sign_a ^ sign_b;
    if (op_is_div(op_in)) begin
      if (op_is_rem(op_in)) begin
        res_neg_in = sign_a;
      end else begin
        res_neg_in = (sign_a ^ sign_b) & ~divisor_zero;
      end
    end
  end

  muldiv_sign_fix #(
    .W     (XLEN),
    .LANES (2)
  ) u_in_fix (
    .value  ({DATA2, DATA1}),
    .negate ({sign_b, sign_a}),
    .result (abs_pair)
  );

  assign abs_a = abs_pair[XLEN-1:0];
  assign abs_b = abs_pair[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Early-out detection
  // ---------------------------------------------------------------------------
  logic            early_hit;
  logic [XLEN-1:0] early_value;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    early_hit   = 1'b0;
    early_value = '0;
    if (op_is_div(op_in)) begin
      if (divisor_zero) begin
        early_hit   = 1'b1;
        early_value = op_is_rem(op_in) ? DATA1 : '1;
      end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (DATA1 == INT_MIN) && (&DATA2)) begin
        early_hit   = 1'b1;
        early_value = op_is_rem(op_in) ? '0 : DATA1;
      end
    end else if ((DATA1 == '0) || divisor_zero) begin
      early_hit   = 1'b1;
      early_value = '0;
    end
  end
`else
  assign early_hit   = 1'b0;
  assign early_value = '0;
`endif

  // ---------------------------------------------------------------------------
  // Iteration step
  // Multiply: {acc_hi, acc_lo} starts as {0, |a|}; each step conditionally adds
  // |b| into the high half and shifts the pair right by one.
  // Divide: acc_lo holds the dividend shifting out MSB-first into the partial
  // remainder acc_hi; quotient bits shift into acc_lo from the bottom.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
    div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, opb_reg});
    // When the subtract is taken the difference is below the divisor, so the
    // low XLEN bits of the modular difference are exact.
    div_diff  = div_shift[XLEN-1:0] - opb_reg;
    if (op_is_div(op_reg)) begin
      step_hi = div_ok ? div_diff : div_shift[XLEN-1:0];
      step_lo = {acc_lo_reg[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Output side: sign correction of the final step's magnitude
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] mag_wide, fixed_wide;
  logic [XLEN-1:0]   final_result;

  // Quotient/remainder are zero-extended so one 2*XLEN negator covers both
  // the product and the divide results.
  assign mag_wide = op_is_div(op_reg)
                  ? {{XLEN{1'b0}}, (op_is_rem(op_reg) ? step_hi : step_lo)}
                  : {step_hi, step_lo};

  muldiv_sign_fix #(
    .W     (2*XLEN),
    .LANES (1)
  ) u_out_fix (
    .value  (mag_wide),
    .negate (res_neg_reg),
    .result (fixed_wide)
  );

  assign final_result = (!op_is_div(op_reg) && (op_reg != OP_MUL))
                      ? fixed_wide[2*XLEN-1:XLEN]
                      : fixed_wide[XLEN-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    BUSY       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        IN_READY = 1'b1;
        BUSY     = 1'b0;
        if (IN_VALID && !KILL) begin
          accept     = 1'b1;
          state_next = early_hit ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (KILL) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (KILL || OUT_READY) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_reg      <= OP_MUL;
      res_neg_reg <= 1'b0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      opb_reg     <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
    end else if (accept) begin
      op_reg      <= op_in;
      res_neg_reg <= res_neg_in;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= abs_a;
      opb_reg     <= abs_b;
      cnt_reg     <= CNT_W'(XLEN - 1);
      if (early_hit) begin
        result_reg <= early_value;
      end
    end else if (state_reg == ST_CALC) begin
      if (KILL) begin
        cnt_reg    <= '0;
        result_reg <= '0;
      end else begin
        acc_hi_reg <= step_hi;
        acc_lo_reg <= step_lo;
        if (cnt_reg == '0) begin
          result_reg <= final_result;
        end else begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end
    end else if ((state_reg == ST_DONE) && KILL) begin
      result_reg <= '0;
    end
  end

  assign RESULT = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int NV      = 23;
  localparam int FULL_LAT = 33;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [2:0]  OP = 3'd0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        KILL = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] RESULT;
  logic        BUSY;

  int n_vec = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32), .OP_W(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OP        (OP),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .KILL      (KILL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    OP = op;
    DATA1 = a;
    DATA2 = b;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    // Scramble the inputs: the unit must have captured them at acceptance.
    IN_VALID = 1'b0;
    OP = ~op;
    DATA1 = ~a;
    DATA2 = a ^ 32'h5a5a_5a5a;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (OUT_VALID !== 1'b1 && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int          lat;
    logic [31:0] res;
    issue(op, a, b);
    wait_valid(lat);
    res = RESULT;
    $display("%s op=%0d a=%h b=%h result=%h latency=%0d", name, op, a, b, res, lat);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    release_out();
    check({name, " in_ready after release"}, {31'd0, IN_READY}, 32'd1);
  endtask

  initial begin
    int          lat;
    bit          seen;
    string       nm;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,        32'd14,       1'b0};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,        32'd2,        1'b0};
    vecs[8]  = '{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{OP_REMU,   32'd5,          32'd0,        32'd5,        1'b1};
    vecs[10] = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[12] = '{OP_DIV,    32'hFFFFFFFA,   32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[13] = '{OP_REM,    32'hFFFFFFFA,   32'd0,        32'hFFFFFFFA, 1'b1};
    vecs[14] = '{OP_MUL,    32'd0,          32'h00012345, 32'd0,        1'b1};
    vecs[15] = '{OP_MULHU,  32'hFFFFFFFF,   32'd0,        32'd0,        1'b1};
    vecs[16] = '{OP_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[17] = '{OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[18] = '{OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[19] = '{OP_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        1'b0};
    vecs[20] = '{OP_MULHU,  32'h00010000,   32'h00010000, 32'd1,        1'b0};
    vecs[21] = '{OP_DIVU,   32'hFFFFFFFF,   32'd10,       32'h19999999, 1'b0};
    vecs[22] = '{OP_REMU,   32'hFFFFFFFF,   32'd10,       32'd5,        1'b0};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("reset in_ready",  {31'd0, IN_READY},  32'd1);
    check("reset out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("reset result",    RESULT,             32'd0);
    check("reset busy",      {31'd0, BUSY},      32'd0);

    // Table-driven vectors, full handshake each
    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("vec%0d", i);
      run_op(nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             (vecs[i].special && EARLY) ? 1 : FULL_LAT);
    end

    // KILL in IDLE blocks acceptance
    IN_VALID = 1'b1;
    OP = OP_DIVU;
    DATA1 = 32'd9;
    DATA2 = 32'd3;
    KILL = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    KILL = 1'b0;
    check("kill idle busy", {31'd0, BUSY}, 32'd0);

    // Backpressure: result held for 4 cycles with OUT_READY low
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    $display("backpressure MULHU result=%h latency=%0d", RESULT, lat);
    check("bp latency", 32'(lat), 32'(FULL_LAT));
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("bp out_valid c%0d", k), {31'd0, OUT_VALID}, 32'd1);
      check($sformatf("bp result c%0d", k),    RESULT,             32'hFFFFFFFE);
      check($sformatf("bp in_ready c%0d", k),  {31'd0, IN_READY},  32'd0);
    end
    release_out();
    check("bp release in_ready",  {31'd0, IN_READY},  32'd1);
    check("bp release out_valid", {31'd0, OUT_VALID}, 32'd0);

    // KILL on cycle 10 of a DIV
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge CLK);
      #1;
    end
    KILL = 1'b1;
    @(posedge CLK);
    #1;
    KILL = 1'b0;
    $display("kill DIV at cycle 10 in_ready=%b busy=%b out_valid=%b", IN_READY, BUSY, OUT_VALID);
    check("kill in_ready",  {31'd0, IN_READY},  32'd1);
    check("kill busy",      {31'd0, BUSY},      32'd0);
    check("kill out_valid", {31'd0, OUT_VALID}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK);
      #1;
      if (OUT_VALID === 1'b1) seen = 1'b1;
    end
    check("kill no out_valid later", {31'd0, seen}, 32'd0);
    run_op("post-kill MUL", OP_MUL, 32'd3, 32'd4, 32'd12, FULL_LAT);

    // RESET on cycle 20 of a MULHU
    issue(OP_MULHU, 32'h12345678, 32'h9ABCDEF0);
    repeat (19) begin
      @(posedge CLK);
      #1;
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    $display("reset MULHU at cycle 20 in_ready=%b out_valid=%b result=%h busy=%b",
             IN_READY, OUT_VALID, RESULT, BUSY);
    check("midreset in_ready",  {31'd0, IN_READY},  32'd1);
    check("midreset out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("midreset result",    RESULT,             32'd0);
    check("midreset busy",      {31'd0, BUSY},      32'd0);
    run_op("post-reset REMU", OP_REMU, 32'd9, 32'd4, 32'd1, FULL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
